// File: rtl/packet_forwarder.sv
// Packet forwarder: drains one stored packet from the packet RAM and streams it
// out as 64-bit valid/ready/last beats (two 32-bit RAM words per beat).
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start, len          forward request and highest written word address
//   busy, done, len_rst status; done/len_rst pulse once when the packet ends
//   rd_addr, rd_en      RAM read request (even word address)
//   rd_data             RAM read data, valid one cycle after rd_en
//   tdata, tvalid,      output stream beat (word rd_addr in [63:32])
//   tready, tlast
module packet_forwarder #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] len,
  output logic                  busy,
  output logic                  done,
  output logic                  len_rst,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic [DATA_WIDTH-1:0] tdata,
  output logic                  tvalid,
  input  logic                  tready,
  output logic                  tlast
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t                  state, state_nx;
  logic [ADDR_WIDTH-1:0]   last_addr;
  logic                    inflight;
  logic                    inflight_last;
  logic [DATA_WIDTH-1:0]   fifo_data [2];
  logic [1:0]              fifo_last;
  logic                    head;
  logic [1:0]              occ;
  logic                    tail_c;
  logic                    pop_c;
  logic [1:0]              credit_c;
  logic                    issue_last_c;

  // Skid FIFO head drives the stream
  assign tvalid  = (occ != 2'd0);
  assign tdata   = fifo_data[head];
  assign tlast   = fifo_last[head] & tvalid;
  assign pop_c   = tvalid & tready;
  assign tail_c  = head ^ (occ == 2'd1);

  // Credit: entries held plus the read in flight, minus the beat leaving now
  assign credit_c     = occ + 2'(inflight) - 2'(pop_c);
  assign rd_en        = (state == READ) && (credit_c < 2'd2);
  assign issue_last_c = rd_en && (rd_addr == last_addr);

  assign busy    = (state != IDLE);
  assign done    = (state == DONE);
  assign len_rst = (state == DONE);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = READ;
      READ:    if (issue_last_c) state_nx = DRAIN;
      DRAIN:   if (pop_c && tlast) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Read address generation; the final read leaves rd_addr at last_addr
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_addr     <= '0;
      rd_addr       <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        last_addr <= {len[ADDR_WIDTH-1:1], 1'b0};
        rd_addr   <= '0;
      end else if (rd_en && !issue_last_c) begin
        rd_addr <= rd_addr + ADDR_WIDTH'(2);
      end
      inflight      <= rd_en;
      inflight_last <= issue_last_c;
    end
  end

  // Two-entry skid FIFO; credit guarantees a write never meets a full FIFO
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_data[0] <= '0;
      fifo_data[1] <= '0;
      fifo_last    <= '0;
      head         <= 1'b0;
      occ          <= 2'd0;
    end else begin
      if (inflight) begin
        fifo_data[tail_c] <= rd_data;
        fifo_last[tail_c] <= inflight_last;
      end
      if (pop_c) head <= ~head;
      occ <= occ + 2'(inflight) - 2'(pop_c);
    end
  end

endmodule

// File: tb/tb_packet_forwarder.sv
// Directed testbench for packet_forwarder with a registered RAM model.
module tb_packet_forwarder;

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] len;
  logic          busy, done, len_rst, rd_en, tvalid, tready, tlast;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic [DW-1:0] tdata;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [0:1023];

  packet_forwarder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .busy(busy), .done(done),
    .len_rst(len_rst), .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data),
    .tdata(tdata), .tvalid(tvalid), .tready(tready), .tlast(tlast)
  );

  always #5 clk = ~clk;

  // Registered RAM read port: words {a, a+1}, output holds when not read
  always @(posedge clk) begin
    if (rd_en) rd_data <= {mem[rd_addr], mem[rd_addr + 10'd1]};
  end

  initial begin
    #2000000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] beat(input int j);
    return {32'(16 + 2 * j), 32'(17 + 2 * j)};
  endfunction

  // Runs one packet; mode 0 = tready high, mode 1 = tready 1,0,0 repeating.
  // Returns on the negedge of the DONE cycle.
  task automatic run_pkt(input logic [AW-1:0] l, input int mode, input bit dup_start);
    int n, j, reads, occ_m, infl_m;
    bit pop, stalled, fin;
    logic [63:0] held;
    n = int'(l) / 2 + 1;
    j = 0; reads = 0; occ_m = 0; infl_m = 0;
    stalled = 0; fin = 0; held = '0;
    @(negedge clk);
    start = 1'b1; len = l; tready = 1'b1;
    #1 chk("idle_at_start", 64'(busy), 64'd0);
    for (int cyc = 1; cyc < 300; cyc++) begin
      @(negedge clk);
      start = (dup_start && cyc == 2);
      len = (cyc == 2) ? 10'd0 : l;
      tready = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
      #1;
      if (cyc == 1) begin
        chk("busy_c1", 64'(busy), 64'd1);
        chk("rd_en_c1", 64'(rd_en), 64'd1);
      end
      pop = tvalid & tready;
      chk("tvalid", 64'(tvalid), 64'(occ_m > 0));
      chk("rd_en_credit", 64'(rd_en && (occ_m + infl_m - int'(pop) >= 2)), 64'd0);
      if (rd_en) begin
        chk("rd_addr", 64'(rd_addr), 64'(2 * reads));
        reads++;
      end
      if (stalled) chk("tdata_stable", tdata, held);
      if (pop) begin
        chk("tdata", tdata, beat(j));
        chk("tlast", 64'(tlast), 64'(j == n - 1));
        j++;
      end
      stalled = tvalid & ~tready;
      held = tdata;
      if (done) begin
        chk("len_rst_done", 64'(len_rst), 64'd1);
        chk("beats", 64'(j), 64'(n));
        chk("reads", 64'(reads), 64'(n));
        fin = 1;
      end
      occ_m = occ_m + infl_m - int'(pop);
      infl_m = int'(rd_en);
      if (fin) break;
    end
    chk("pkt_finished", 64'(fin), 64'd1);
    start = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'(16 + i);
    rst = 1'b1; start = 1'b0; len = '0; tready = 1'b0; rd_data = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_rd_en", 64'(rd_en), 64'd0);
    chk("rst_tvalid", 64'(tvalid), 64'd0);
    chk("rst_tdata", tdata, 64'd0);
    chk("rst_rd_addr", 64'(rd_addr), 64'd0);
    rst = 1'b0;

    // Full rate, len=6, cycle-exact
    @(negedge clk);
    start = 1'b1; len = 10'd6; tready = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      chk("fr_rd_en", 64'(rd_en), 64'(c >= 1 && c <= 4));
      if (c <= 4) chk("fr_rd_addr", 64'(rd_addr), 64'(2 * (c - 1)));
      chk("fr_tvalid", 64'(tvalid), 64'(c >= 3 && c <= 6));
      if (c >= 3 && c <= 6) chk("fr_tdata", tdata, beat(c - 3));
      chk("fr_tlast", 64'(tlast), 64'(c == 6));
      chk("fr_done", 64'(done), 64'(c == 7));
      chk("fr_len_rst", 64'(len_rst), 64'(c == 7));
      chk("fr_busy", 64'(busy), 64'(c <= 7));
    end

    // Backpressure, len=6
    run_pkt(10'd6, 1, 0);
    // len=0 single beat, odd len=5 with backpressure
    run_pkt(10'd0, 0, 0);
    run_pkt(10'd5, 1, 0);

    // start while busy is ignored
    run_pkt(10'd6, 0, 1);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      chk("dup_busy", 64'(busy), 64'd0);
      chk("dup_rd_en", 64'(rd_en), 64'd0);
      chk("dup_done", 64'(done), 64'd0);
    end

    // Asynchronous reset mid-packet
    @(negedge clk);
    start = 1'b1; len = 10'd6; tready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      start = 1'b0;
    end
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("ar_busy", 64'(busy), 64'd0);
    chk("ar_tvalid", 64'(tvalid), 64'd0);
    chk("ar_tlast", 64'(tlast), 64'd0);
    chk("ar_tdata", tdata, 64'd0);
    chk("ar_rd_en", 64'(rd_en), 64'd0);
    chk("ar_rd_addr", 64'(rd_addr), 64'd0);
    chk("ar_len_rst", 64'(len_rst), 64'd0);
    chk("ar_done", 64'(done), 64'd0);
    @(negedge clk);
    #1 chk("ar_len_rst_hold", 64'(len_rst), 64'd0);
    rst = 1'b0;
    run_pkt(10'd2, 0, 0);

    // Back-to-back: new start in the cycle after DONE
    run_pkt(10'd6, 0, 0);
    run_pkt(10'd2, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/packet_forwarder.md
# packet_forwarder

Drains one stored packet out of the packet RAM and presents it as a 64-bit valid/ready/last stream, eight bytes per beat. It sits on the read side of the packet RAM, behind the filter VM. Once a packet is accepted, the forwarder reads back exactly what the packet writer stored. When the last beat has been accepted, it releases the RAM's length register.

## Interface
- ADDR_WIDTH, 10, packet RAM word address width (32-bit words).
- DATA_WIDTH, 64, RAM read width and stream beat width (two 32-bit words).
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to forward the stored packet; sampled only in IDLE.
- len  in  ADDR_WIDTH  highest word address written by the packet writer (the RAM's length register).
- busy  out  1  high from the cycle after an accepted start through the DONE cycle.
- done  out  1  one-cycle pulse in DONE.
- len_rst  out  1  one-cycle pulse in DONE; drives the RAM's length reset.
- rd_addr  out  ADDR_WIDTH  RAM read address, always even.
- rd_en  out  1  RAM read enable.
- rd_data  in  DATA_WIDTH  RAM data: words {rd_addr, rd_addr+1}, valid one cycle after rd_en.
- tdata  out  DATA_WIDTH  stream beat; word rd_addr in [63:32].
- tvalid  out  1  beat valid.
- tready  in  1  sink accepts the beat.
- tlast  out  1  marks the final beat of the packet.

## Operation
- States: IDLE, READ, DRAIN, DONE.
- IDLE → READ on start=1. The block latches last_addr = len with bit 0 forced to 0 (odd len is treated as len-1) and sets rd_addr=0.
- start while not IDLE is ignored.
- READ behaviour:
  - rd_en=1 when occ + inflight − pop < 2, where:
    - occ = skid FIFO occupancy (0..2);
    - inflight = 1 if rd_en was high in the previous cycle;
    - pop = tvalid & tready.
  - Each issued read advances rd_addr by 2.
  - The read issued at rd_addr == last_addr moves the FSM to DRAIN.
- DRAIN: no reads. DRAIN → DONE when the beat with tlast=1 is accepted.
- DONE: done=1, len_rst=1 for one cycle, then → IDLE.
- Skid FIFO: 2 entries, each carrying {data, last}.
  - The entry is written in the cycle rd_data is valid.
  - Its last flag = 1 iff the issuing address was last_addr.
- tvalid = FIFO non-empty; tdata/tlast come from the FIFO head.
- tdata is stable while tvalid=1 and tready=0.
- Beat count = last_addr/2 + 1. len=0 gives one beat with tlast=1.
- rd_en=0 and rd_addr hold in IDLE, DRAIN and DONE. The RAM output register therefore holds its value when not read.
- len is sampled only at start; changes during busy are ignored.
- rst (any time, including mid-packet):
  - state → IDLE, FIFO emptied, inflight cleared;
  - busy=0, done=0, len_rst=0, rd_en=0, rd_addr=0, tvalid=0, tlast=0, tdata=0.
  - The partially sent packet is abandoned, and len_rst is not pulsed.
- Arithmetic:
  - rd_addr is ADDR_WIDTH bits; the +2 increment never wraps, because last_addr ≤ 2^ADDR_WIDTH−2.
  - The occupancy/credit compare uses 2-bit unsigned values.

## Timing
- Cycle 0: start sampled in IDLE.
- Cycle 1: busy=1, rd_en=1, rd_addr=0.
- Cycle 2: rd_data valid, written to FIFO.
- Cycle 3: first tvalid=1.
- Start-to-first-beat latency: 3 cycles.
- With tready held high: one read and one beat per cycle, no bubbles.
- tready falls: at most one further read issues. FIFO fills to 2 and rd_en=0 until a pop frees credit.
- rd_en depends combinationally on tready (pop credit). This is the only combinational input-to-output path.
- Last beat accepted in cycle k: DONE (done=1, len_rst=1) in cycle k+1. IDLE with busy=0 in k+2; a new start is accepted in k+2.

## Test plan
- Full rate, len=6, tready=1, RAM words 0..7 = 0x10..0x17, start at cycle 0:
  - rd_addr 0,2,4,6 in cycles 1–4;
  - beats 0x00000010_00000011 … 0x00000016_00000017 in cycles 3–6, tlast only in cycle 6;
  - done/len_rst in cycle 7, busy=0 in cycle 8.
- Backpressure, len=6: tready toggles 1,0,0,1… → all 4 beats in order, no duplicates or losses, tdata stable while stalled, rd_en never issued with FIFO full, done after the 4th beat.
- len=0 and odd len=5:
  - len=0 → single beat (words 0,1) with tlast=1;
  - len=5 → 3 beats (addresses 0,2,4), tlast on address 4.
- start pulsed in cycle 2 while busy → ignored; exactly one packet sent, one done pulse.
- rst asserted asynchronously after beat 1 of len=6 → all outputs 0 immediately, no len_rst pulse. A following start with len=2 sends 2 beats starting at address 0.
- Back-to-back: start in the cycle after DONE → accepted; second packet begins rd_en at +1 cycle.
